// File: rtl/register_file_stream_reader_if.sv
// Valid/ready stream carrying register-file words out of the reader.
// The master drives the data side and the slave drives the ready.
interface register_file_stream_reader_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;

  modport master (output m_valid, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/register_file_stream_reader.sv
// Read-side streamer for the scoring register file: walks a wrapping address range
// and re-emits the one-cycle-latency read data as a backpressured stream.
module register_file_stream_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 128,
  parameter int LEN_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [31:0]           base_addr,
  input  logic [LEN_W-1:0]      length,
  output logic [31:0]           r_addr,
  input  logic [DATA_WIDTH-1:0] r_data,
  register_file_stream_reader_if.master strm,
  output logic                  busy,
  output logic                  done
);
  localparam int AW     = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int CW     = (CNT_W > LEN_W) ? CNT_W : LEN_W;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t state, state_next;

  logic [AW-1:0]         base, last_addr, issue_addr;
  logic [CW-1:0]         len, issued, length_ext, len_clamped;
  logic                  inflight, inflight_last;
  logic [DATA_WIDTH-1:0] fifo_data [2];
  logic                  fifo_last [2];
  logic                  rd_ptr, wr_ptr;
  logic [1:0]            count;
  logic [2:0]            credit;
  logic                  accept, issue, push, pop, head_last, final_issue, done_next;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^base_addr[31:AW];

  assign length_ext  = CW'(length);
  assign len_clamped = (length_ext > CW'(DEPTH)) ? CW'(DEPTH) : length_ext;
  assign accept      = (state == IDLE) && start;

  // Issue stage: a word popped this cycle frees its slot, keeping 1 word/cycle under full flow
  assign pop         = strm.m_valid && strm.m_ready;
  assign credit      = {1'b0, count} + {2'b00, inflight};
  assign issue       = (state == ISSUE) && (issued < len) && (credit < (3'd2 + {2'b00, pop}));
  assign issue_addr  = base + issued[AW-1:0];
  assign final_issue = issue && ((issued + CW'(1)) == len);
  assign r_addr      = 32'(issue ? issue_addr : last_addr);

  // Output stage: head of the 2-entry buffer, forced to zero while empty
  assign push         = inflight;
  assign head_last    = fifo_last[rd_ptr];
  assign strm.m_valid = (count != 2'd0);
  assign strm.m_data  = strm.m_valid ? fifo_data[rd_ptr] : '0;
  assign strm.m_last  = strm.m_valid && head_last;
  assign busy         = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (len_clamped == '0) done_next  = 1'b1;
          else                   state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (final_issue) state_next = DRAIN;
      end
      DRAIN: begin
        if (pop && head_last) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base          <= '0;
      len           <= '0;
      issued        <= '0;
      last_addr     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      rd_ptr        <= 1'b0;
      wr_ptr        <= 1'b0;
      count         <= 2'd0;
      done          <= 1'b0;
    end else begin
      if (accept) begin
        base   <= base_addr[AW-1:0];
        len    <= len_clamped;
        issued <= '0;
      end else if (issue) begin
        issued <= issued + CW'(1);
      end
      if (issue) last_addr <= issue_addr;
      inflight      <= issue;
      inflight_last <= final_issue;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      done <= done_next;
    end
  end

  // Capture stage: read data lands in the buffer one cycle after its address was issued
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= r_data;
      fifo_last[wr_ptr] <= inflight_last;
    end
  end
endmodule

// File: tb/tb_register_file_stream_reader.sv
// Randomised and directed bench for register_file_stream_reader against a
// queue-based model of the expected word sequence of each transfer.
module tb_register_file_stream_reader;
  localparam int DW = 32;
  localparam int DEPTH = 128;
  localparam int BUDGET = 600;

  logic clk, rst, start, busy, done;
  logic [31:0] base_addr, r_addr;
  logic [7:0]  length;
  logic [DW-1:0] r_data;
  logic [DW-1:0] mem [DEPTH];

  int checks, errors;
  int addr_seq[$];

  register_file_stream_reader_if #(.DATA_WIDTH(DW)) strm ();

  register_file_stream_reader #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .LEN_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .r_addr(r_addr), .r_data(r_data), .strm(strm.master), .busy(busy), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) r_data <= mem[r_addr[6:0]];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic ready_for(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return (k % 3) == 1;
      default: return $urandom_range(0, 3) != 0 ? 1'b1 : ($urandom_range(0, 1) == 1);
    endcase
  endfunction

  task automatic run_xfer(input logic [31:0] base, input int len, input int mode,
                          input bit chk_lat, input bit restart);
    logic [32:0] exp_q[$];
    logic [6:0]  a;
    logic [31:0] prev_data;
    logic        prev_last, prev_stall, busy_at_done;
    int L, k, beats, last_k, done_k, first_v;
    L = (len > DEPTH) ? DEPTH : len;
    for (int i = 0; i < L; i++) begin
      a = base[6:0] + 7'(i);
      exp_q.push_back({(i == L - 1), mem[a]});
    end
    addr_seq.delete();
    @(negedge clk);
    start = 1'b1; base_addr = base; length = 8'(len); strm.m_ready = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    k = 0; beats = 0; last_k = 0; done_k = -1; first_v = -1;
    prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0; busy_at_done = 1'b1;
    while (k < BUDGET && done_k < 0) begin
      @(negedge clk);
      k++;
      strm.m_ready = ready_for(mode, k);
      if (restart && k == 4) begin start = 1'b1; base_addr = 32'd77; length = 8'd3; end
      if (restart && k == 5) begin start = 1'b0; base_addr = base; length = 8'(len); end
      #1;
      if (busy && (addr_seq.size() == 0 || addr_seq[$] != int'(r_addr))) addr_seq.push_back(int'(r_addr));
      if (prev_stall) begin
        check_val("stall_valid", 32'(strm.m_valid), 32'd1);
        check_val("stall_data", strm.m_data, prev_data);
        check_val("stall_last", 32'(strm.m_last), 32'(prev_last));
      end
      if (strm.m_valid && first_v < 0) first_v = k;
      if (strm.m_valid && strm.m_ready) begin
        if (exp_q.size() == 0) begin
          check_val("extra_beat", 32'(beats + 1), 32'(L));
        end else begin
          check_val("beat_data", strm.m_data, exp_q[0][31:0]);
          check_val("beat_last", 32'(strm.m_last), 32'(exp_q[0][32]));
          void'(exp_q.pop_front());
        end
        beats++;
        last_k = k;
      end
      prev_stall = strm.m_valid && !strm.m_ready;
      prev_data  = strm.m_data;
      prev_last  = strm.m_last;
      if (done) begin done_k = k; busy_at_done = busy; end
    end
    check_val("beat_count", 32'(beats), 32'(L));
    check_val("done_cycle", 32'(done_k), 32'(last_k + 1));
    check_val("busy_at_done", 32'(busy_at_done), 32'd0);
    if (chk_lat) check_val("first_valid_cycle", 32'(first_v), 32'd3);
    for (int j = 0; j < 2; j++) begin
      @(negedge clk); #1;
      check_val("post_done", 32'(done), 32'd0);
      check_val("post_valid", 32'(strm.m_valid), 32'd0);
      check_val("post_busy", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    int nb;
    int exp_addr[4];
    checks = 0; errors = 0;
    rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; strm.m_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'(i + 100);
    #2;
    check_val("rst_valid", 32'(strm.m_valid), 32'd0);
    check_val("rst_data", strm.m_data, 32'd0);
    check_val("rst_addr", r_addr, 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_xfer(32'd5, 4, 0, 1'b1, 1'b0);
    run_xfer(32'd126, 4, 0, 1'b1, 1'b0);
    exp_addr = '{126, 127, 0, 1};
    check_val("wrap_addr_count", 32'(addr_seq.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < addr_seq.size()) check_val("wrap_addr", 32'(addr_seq[i]), 32'(exp_addr[i]));
    run_xfer(32'd3, 8, 1, 1'b0, 1'b0);
    run_xfer(32'd0, 0, 0, 1'b0, 1'b0);
    run_xfer(32'd10, 200, 0, 1'b1, 1'b0);
    run_xfer(32'd30, 12, 0, 1'b1, 1'b1);

    // Abort mid-transfer while the third beat is on the bus
    @(negedge clk);
    start = 1'b1; base_addr = 32'd20; length = 8'd10; strm.m_ready = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    nb = 0;
    for (int c = 0; c < 30 && nb < 3; c++) begin
      @(negedge clk); #1;
      if (strm.m_valid && strm.m_ready) nb++;
    end
    check_val("abort_reached_beat3", 32'(nb), 32'd3);
    rst = 1'b1;
    #1;
    check_val("abort_valid", 32'(strm.m_valid), 32'd0);
    check_val("abort_data", strm.m_data, 32'd0);
    check_val("abort_last", 32'(strm.m_last), 32'd0);
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_done", 32'(done), 32'd0);
    check_val("abort_addr", r_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      check_val("abort_no_done", 32'(done), 32'd0);
      check_val("abort_idle_valid", 32'(strm.m_valid), 32'd0);
    end
    run_xfer(32'd40, 6, 0, 1'b1, 1'b0);

    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    for (int t = 0; t < 8; t++) begin
      run_xfer($urandom, (t == 3) ? 0 : int'($urandom_range(1, 24)), 2, 1'b0, 1'b0);
    end
    run_xfer($urandom, 20, 1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
